// File: rtl/simon_pkg.sv
// Shared Simon 32/64 geometry, constants, helpers and FSM encoding.
package simon_pkg;

    localparam int WORD      = 16;
    localparam int ROUNDS    = 32;
    localparam int KEY_WORDS = 4;

    localparam logic [WORD-1:0] C_CONST = 16'hFFFC;

    // z0 sequence with z[0] in bit 0.
    localparam logic [61:0] Z0 =
        62'b01100111000011010100100010111110110011100001101010010001011111;

    // Last counter value of the forward expansion (produces k31).
    localparam logic [4:0] EXP_LAST = 5'(ROUNDS - KEY_WORDS - 1);
    localparam logic [4:0] CNT_TOP  = 5'(ROUNDS - 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_EXPAND  = 2'd1;
    localparam state_t ST_DECRYPT = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    function automatic logic [WORD-1:0] rotl16(input logic [WORD-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rotr16(input logic [WORD-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
        return (rotl16(v, 1) & rotl16(v, 8)) ^ rotl16(v, 2);
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One step of the Simon 32/64 key schedule, forward (dir=0) or inverse (dir=1).
// Window w0..w3 is oldest..newest. Forward yields the word after w3,
// inverse yields the word before w0.
module simon_key_step
    import simon_pkg::*;
(
    input  logic            dir,
    input  logic [WORD-1:0] w0,
    input  logic [WORD-1:0] w1,
    input  logic [WORD-1:0] w2,
    input  logic [WORD-1:0] w3,
    input  logic            zbit,
    output logic [WORD-1:0] knext
);

    logic [WORD-1:0] base;
    logic [WORD-1:0] ta;
    logic [WORD-1:0] tb;
    logic [WORD-1:0] t;

    // Both directions share one mixing datapath; only the operand choice differs.
    always_comb begin
        base  = dir ? w3 : w0;
        ta    = dir ? w2 : w3;
        tb    = dir ? w0 : w1;
        t     = rotr16(ta, 3) ^ tb;
        knext = base ^ C_CONST ^ {{(WORD-1){1'b0}}, zbit} ^ t ^ rotr16(t, 1);
    end

endmodule

// File: rtl/simon_decrypt_iter.sv
// Iterative Simon 32/64 decryptor: forward key expansion to k31..k28,
// then 32 inverse rounds while walking the key schedule backwards.
//
// state      | meaning
// IDLE       | ready for a ciphertext/key pair
// EXPAND     | forward key schedule, 28 cycles, ends with w3 = k31
// DECRYPT    | 32 inverse rounds using w3 = k[cnt], regenerating k[cnt-4]
// DONE       | plaintext held until out_ready
module simon_decrypt_iter
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ciphertext,
    input  logic [63:0] keytext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] plaintext
);

    state_t          state;
    logic [4:0]      cnt;
    logic [WORD-1:0] w0, w1, w2, w3;
    logic [WORD-1:0] x, y;
    logic [WORD-1:0] knext;
    logic [4:0]      zidx;
    logic            zbit;

    // z index: cnt going forward, cnt-4 going backward (held at 0 when unused).
    always_comb begin
        zidx = 5'd0;
        if (state == ST_EXPAND)
            zidx = cnt;
        else if (cnt >= 5'd4)
            zidx = cnt - 5'd4;
        zbit = Z0[zidx];
    end

    simon_key_step u_key_step (
        .dir   (state == ST_DECRYPT),
        .w0    (w0),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .zbit  (zbit),
        .knext (knext)
    );

    // Sequencer, key window and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w0    <= keytext[15:0];
                        w1    <= keytext[31:16];
                        w2    <= keytext[47:32];
                        w3    <= keytext[63:48];
                        x     <= ciphertext[31:16];
                        y     <= ciphertext[15:0];
                        cnt   <= 5'd0;
                        state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    w0 <= w1;
                    w1 <= w2;
                    w2 <= w3;
                    w3 <= knext;
                    if (cnt == EXP_LAST) begin
                        cnt   <= CNT_TOP;
                        state <= ST_DECRYPT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DECRYPT: begin
                    x  <= y;
                    y  <= x ^ simon_f(y) ^ w3;
                    w3 <= w2;
                    w2 <= w1;
                    w1 <= w0;
                    w0 <= knext;
                    if (cnt == 5'd0)
                        state <= ST_DONE;
                    else
                        cnt <= cnt - 5'd1;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign plaintext = {x, y};

endmodule

// File: tb/tb_simon_decrypt_iter.sv
module tb_simon_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ciphertext = '0;
    logic [63:0] keytext = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] plaintext;

    localparam logic [63:0] KEY = 64'h1918111009080100;
    localparam logic [31:0] CT0 = 32'hC69BE9BB;
    localparam logic [31:0] PT0 = 32'h65656877;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;
    int n_acc = 0;
    int acc_q[$];

    simon_decrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .keytext    (keytext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic logic [511:0] schedule(input logic [63:0] key);
        string zs = "11111010001001010110000111001101111101000100101011000011100110";
        logic [15:0] k[32];
        logic [15:0] tmp;
        logic [511:0] s;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp = ror(k[i-1], 3) ^ k[i-3];
            tmp = tmp ^ ror(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ 16'd3 ^ ((zs[i-4] == 8'd49) ? 16'd1 : 16'd0);
        end
        for (int i = 0; i < 32; i++) s[16*i +: 16] = k[i];
        return s;
    endfunction

    function automatic logic [31:0] model_encrypt(input logic [31:0] pt, input logic [63:0] key);
        logic [511:0] s = schedule(key);
        logic [15:0] x = pt[31:16];
        logic [15:0] y = pt[15:0];
        logic [15:0] t;
        for (int r = 0; r < 32; r++) begin
            t = x;
            x = y ^ ff(x) ^ s[16*r +: 16];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] model_decrypt(input logic [31:0] ct, input logic [63:0] key);
        logic [511:0] s = schedule(key);
        logic [15:0] x = ct[31:16];
        logic [15:0] y = ct[15:0];
        logic [15:0] t;
        for (int r = 31; r >= 0; r--) begin
            t = y;
            y = x ^ ff(y) ^ s[16*r +: 16];
            x = t;
        end
        return {x, y};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Cycle-by-cycle compare against the transaction-level model.
    bit          busy = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_pt = '0;

    always @(negedge clk) begin
        bit exp_ov;
        if (rst) begin
            busy = 0;
        end else begin
            exp_ov = busy && (cyc >= acc_cyc + 60);
            chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov) chk("plaintext", plaintext, exp_pt);
            if (!busy && in_valid) begin
                busy    = 1;
                acc_cyc = cyc + 1;
                exp_pt  = model_decrypt(ciphertext, keytext);
                acc_q.push_back(cyc + 1);
                n_acc++;
            end else if (exp_ov && out_ready) begin
                busy = 0;
            end
        end
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic send(input logic [31:0] ct, input logic [63:0] key);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) timeout_fail("send_wait_ready");
        in_valid   = 1'b1;
        ciphertext = ct;
        keytext    = key;
        @(posedge clk); #1;
        last_acc   = cyc;
        in_valid   = 1'b0;
        ciphertext = $urandom;
        keytext    = {$urandom, $urandom};
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 150) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) timeout_fail(name);
    endtask

    task automatic recv(input string name, input logic [31:0] exp);
        wait_out(name);
        chk(name, plaintext, exp);
        chk("latency", cyc - last_acc, 32'd60);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rt_pt[3];
        logic [31:0] pt2, ct2, rp;
        logic [63:0] k2, rk;
        int n, base;
        rt_pt[0] = 32'h41424344;
        rt_pt[1] = 32'h345A6B7C;
        rt_pt[2] = 32'h78569043;

        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_plaintext", plaintext, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // pin the model on the published vector
        chk("model_encrypt", model_encrypt(PT0, KEY), CT0);
        chk("model_decrypt", model_decrypt(CT0, KEY), PT0);

        // official vector
        send(CT0, KEY);
        recv("official", PT0);

        // round trip with the encryptor
        for (int i = 0; i < 3; i++) begin
            send(model_encrypt(rt_pt[i], KEY), KEY);
            recv("round_trip", rt_pt[i]);
        end

        // backpressure
        out_ready = 1'b0;
        send(CT0, KEY);
        wait_out("bp_wait");
        repeat (20) begin
            @(posedge clk); #1;
            chk("bp_plaintext", plaintext, PT0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

        // in_valid noise while busy
        send(CT0, KEY);
        repeat (50) begin
            in_valid   = 1'($urandom % 2);
            ciphertext = $urandom;
            keytext    = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        recv("ignore_in_valid", PT0);

        // reset at cycle 40 of a transaction
        send(CT0, KEY);
        repeat (39) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_plaintext", plaintext, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        n = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("abort_no_output", n, 32'd0);
        send(CT0, KEY);
        recv("after_abort", PT0);

        // back-to-back with in_valid held high
        k2  = {$urandom, $urandom};
        pt2 = $urandom;
        ct2 = model_encrypt(pt2, k2);
        base = n_acc;
        in_valid   = 1'b1;
        ciphertext = CT0;
        keytext    = KEY;
        @(posedge clk); #1;
        ciphertext = ct2;
        keytext    = k2;
        n = 0;
        while (n_acc < base + 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        last_acc = cyc;
        in_valid = 1'b0;
        if (n_acc < base + 2) timeout_fail("b2b_second_accept");
        else chk("b2b_spacing", acc_q[$] - acc_q[$-1], 32'd62);
        recv("b2b_second", pt2);

        // random vectors with random output stalls
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            send(model_encrypt(rp, rk), rk);
            wait_out("rand_wait");
            out_ready = 1'b0;
            repeat ($urandom % 5) begin @(posedge clk); #1; end
            chk("rand_plaintext", plaintext, rp);
            out_ready = 1'b1;
            @(posedge clk); #1;
            repeat ($urandom % 4) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simon_decrypt_iter.md
# simon_decrypt_iter

Iterative Simon 32/64 block decryptor, the inverse of the `simon_pipeline` encryptor. It accepts one 32-bit ciphertext and 64-bit key per transaction over a valid/ready handshake. It expands the key forward to recover the last four round keys, then runs 32 inverse rounds in reverse key order while regenerating earlier keys with the inverse key schedule. It sits on the receive side of the encryptor and returns plaintext over a second valid/ready handshake.

## Interface
- No parameters. Geometry is fixed in `simon_pkg`: word 16 bits, 4 key words, 32 rounds, z0 sequence.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `ciphertext` and `keytext` are valid.
- `in_ready` out 1: block is idle and can accept a transaction.
- `ciphertext` in 32: `{x[15:0], y[15:0]}`, with x in the upper half.
- `keytext` in 64: `{k3,k2,k1,k0}`, with k0 = `keytext[15:0]`. Same ordering as the encryptor.
- `out_valid` out 1: `plaintext` is valid. Held until accepted.
- `out_ready` in 1: downstream accepts `plaintext`.
- `plaintext` out 32: `{x, y}` after decryption.

## Operation
- Definitions:
  - f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2).
  - c = 16'hFFFC.
  - z = z0 bit sequence, bit 0 first.
- Forward key step: k[i+4] = c ^ z[i] ^ k[i] ^ t ^ rotr(t,1), where t = rotr(k[i+3],3) ^ k[i+1].
- Inverse key step: k[i-4] = k[i] ^ c ^ z[i-4] ^ t ^ rotr(t,1), where t = rotr(k[i-1],3) ^ k[i-3].
- Inverse round with key k: x' = y; y' = x ^ f(y) ^ k.
- State: 4-word key window `w3..w0`, data regs `x, y`, 5-bit round counter `cnt`.
- FSM states: IDLE, EXPAND, DECRYPT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: load the window with k3..k0, load `x, y` from `ciphertext`, set `cnt`=0, go to EXPAND.
- EXPAND:
  - Each cycle: shift in k[cnt+4] as the new `w3` (oldest word drops out), then cnt++.
  - On the edge where cnt==27: window now holds k31..k28 (`w3`=k31). Set `cnt`=31 and go to DECRYPT.
- DECRYPT:
  - Each cycle: apply the inverse round with `w3` (= k[cnt]).
  - Shift in k[cnt-4] from the inverse key step at the bottom of the window, then cnt--.
  - The inverse-step output is don't-care when cnt<4, but it must not be X-propagating: gate z index to 0.
  - On the edge where cnt==0: go to DONE.
- DONE:
  - `out_valid`=1; `plaintext`={x,y}, stable.
  - On `out_ready`: go to IDLE.
- `keytext` and `ciphertext` are sampled only on the acceptance edge. Later changes have no effect.
- `in_valid` in any state other than IDLE is ignored; `in_ready`=0 there.
- In DONE with `in_valid` and `out_ready` both high: the output completes and the input is not accepted until the next IDLE cycle.
- All arithmetic is XOR/AND/rotate on 16-bit words. No carries.

## Timing
- Reset (async assert): state=IDLE, `in_ready`=1, `out_valid`=0, `plaintext`=0, `cnt`=0, key window and data regs=0.
- Deassertion is synchronous to `clk`.
- Acceptance edge T (`in_valid`&`in_ready`). EXPAND covers edges T+1..T+28; DECRYPT covers edges T+29..T+60.
- `out_valid` rises after edge T+60: latency 60 cycles.
- Output accepted at edge D (`out_valid`&`out_ready`). `in_ready` is high in the following cycle.
- Minimum spacing between acceptances is 62 cycles.
- Reset mid-EXPAND or mid-DECRYPT aborts the transaction immediately. No output is produced.
- `out_ready` low holds DONE indefinitely with `plaintext` stable.

## Structure
- `simon_pkg` holds:
  - `WORD`=16, `ROUNDS`=32, `KEY_WORDS`=4.
  - `C_CONST`=16'hFFFC.
  - `Z0` as a 62-bit constant.
  - Functions `simon_f`, `rotl16`, `rotr16`.
  - FSM state enum.
  - Shared with `simon_pipeline`.
- One sub-module, `simon_key_step`: combinational. Inputs `dir`, four key words, z bit. Output is the next key word, forward or inverse.
- Top holds the FSM, counter, window, and data regs.

## Test plan
- Official vector: key 64'h1918111009080100, ciphertext 32'hC69BE9BB → plaintext 32'h65656877, `out_valid` exactly 60 cycles after acceptance.
- Round trip with the encryptor: encrypt 32'h41424344, 32'h345A6B7C, 32'h78569043 under key 64'h1918111009080100; feed each ciphertext → the original plaintexts are recovered in order.
- Backpressure: `out_ready` low for 20 cycles after `out_valid` → `plaintext` stable, `in_ready`=0; accept → `in_ready`=1 next cycle.
- `in_valid` toggled with different data during EXPAND/DECRYPT → ignored; result still 32'h65656877.
- `rst` pulsed at cycle 40 of a transaction → all outputs 0 immediately, `out_valid` never asserts; a new transaction then decrypts correctly.
- Back-to-back: `in_valid` held high, `out_ready` high, two vectors → acceptances 62 cycles apart, both results correct.
